// File: rtl/dmem_pkg.sv
// dmem_pkg: access-type codes, FSM encoding and the
// load-align / store-merge helpers for the data-memory controller.
package dmem_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    function automatic logic [31:0] load_ext(
        input logic [31:0] w,
        input logic [1:0]  off,
        input logic [2:0]  t
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        r = w;
        unique case (1'b1)
            t == DM_HALF:   r = {{16{h[15]}}, h};
            t == DM_HALF_U: r = {16'h0000, h};
            t == DM_BYTE:   r = {{24{b[7]}}, b};
            t == DM_BYTE_U: r = {24'h000000, b};
            default:        r = w;
        endcase
        return r;
    endfunction

    // Lane enables plus the full merged word (old bytes kept).
    function automatic wr_t store_merge(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic [1:0]  off,
        input logic [2:0]  t
    );
        wr_t         r;
        logic [31:0] d;
        r.be = 4'b1111;
        d    = wd;
        unique case (1'b1)
            t == DM_HALF,
            t == DM_HALF_U: begin
                r.be = off[1] ? 4'b1100 : 4'b0011;
                d    = {2{wd[15:0]}};
            end
            t == DM_BYTE,
            t == DM_BYTE_U: begin
                r.be = 4'b0001 << off;
                d    = {4{wd[7:0]}};
            end
            default: begin
                r.be = 4'b1111;
                d    = wd;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            r.data[8*i +: 8] = r.be[i] ? d[8*i +: 8]
                                       : old[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: MEM-stage to data-memory request/done bundle.
interface dmem_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dmtype;
    logic [31:0] pc;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        stall;

    modport master (
        output req, we, addr, wdata, dmtype, pc,
        input  done, rdata, err, stall
    );

    modport slave (
        input  req, we, addr, wdata, dmtype, pc,
        output done, rdata, err, stall
    );

endinterface

// File: rtl/dmem_ram.sv
// dmem_ram: sync 32-bit word RAM,
// byte-enable write, registered read.
module dmem_ram #(
  parameter int ADDR_W    = 10,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[waddr][8*i +: 8] <=
            wdata[8*i +: 8];
        end
      end
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: wait-state data-memory controller with sub-word access.
// Define DMEM_TRACE_EN to print committed stores and error completions.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int WAIT_CYC  = 1,
    parameter     INIT_FILE = ""
) (
    input  logic    clk,
    input  logic    reset,
    dmem_if.slave   bus
);

    localparam logic [3:0] WLAST =
        4'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

    state_t            state, nstate;
    logic [3:0]        cnt, ncnt;
    logic              l_we;
    logic [1:0]        l_off;
    logic [ADDR_W-1:0] l_idx;
    logic [31:0]       l_wdata;
    logic [2:0]        l_type;
    logic              accept;
    logic              bad;
    logic              ram_we;
    logic [ADDR_W-1:0] raddr;
    logic [31:0]       q;
    wr_t               wr;

    assign accept = (state == S_IDLE) && bus.req;

    always_comb begin
        nstate = state;
        ncnt   = cnt;
        unique case (state)
            S_IDLE: begin
                if (bus.req) begin
                    ncnt   = 4'd0;
                    nstate = (WAIT_CYC == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == WLAST) nstate = S_RESP;
                else              ncnt   = cnt + 4'd1;
            end
            S_RESP:  nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= nstate;
            cnt   <= ncnt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            l_we    <= bus.we;
            l_off   <= bus.addr[1:0];
            l_idx   <= bus.addr[ADDR_W+1:2];
            l_wdata <= bus.wdata;
            l_type  <= bus.dmtype;
        end
    end

    always_comb begin
        bad = 1'b0;
        unique case (1'b1)
            l_type == DM_WORD:   bad = (l_off != 2'b00);
            l_type == DM_HALF,
            l_type == DM_HALF_U: bad = l_off[0];
            l_type == DM_BYTE,
            l_type == DM_BYTE_U: bad = 1'b0;
            default:             bad = 1'b1;
        endcase
    end

    // While idle the RAM already reads the incoming word so a
    // zero-wait access has its data ready in the response cycle.
    assign raddr  = (state == S_IDLE) ? bus.addr[ADDR_W+1:2]
                                      : l_idx;
    assign wr     = store_merge(q, l_wdata, l_off, l_type);
    assign ram_we = (state == S_RESP) && l_we && !bad && !reset;

    dmem_ram #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (wr.be),
        .waddr (l_idx),
        .wdata (wr.data),
        .raddr (raddr),
        .rdata (q)
    );

    assign bus.done  = (state == S_RESP) && !reset;
    assign bus.err   = bus.done && bad;
    assign bus.rdata = (bus.done && !bad && !l_we)
                     ? load_ext(q, l_off, l_type)
                     : 32'h0;
    assign bus.stall = accept || (state == S_WAIT);

`ifdef DMEM_TRACE_EN
    logic [31:0] l_pc;
    logic [31:0] l_addr;

    always_ff @(posedge clk) begin
        if (accept) begin
            l_pc   <= bus.pc;
            l_addr <= bus.addr;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            $display("pc = %h: dataaddr = %h, memdata = %h",
                     l_pc, l_addr, wr.data);
        end
        if (bus.done && bad) begin
            $display("pc = %h: dmem err addr = %h type = %b",
                     l_pc, l_addr, l_type);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed accesses against a word-array model;
// two instances cover WAIT_CYC=2/ADDR_W=10 and WAIT_CYC=0/ADDR_W=4.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0;
    logic rst1;

    dmem_if b0 ();
    dmem_if b1 ();

    dmem_ctrl #(.ADDR_W(10), .WAIT_CYC(2), .INIT_FILE("")) u0 (
        .clk   (clk),
        .reset (rst0),
        .bus   (b0.slave)
    );

    dmem_ctrl #(.ADDR_W(4), .WAIT_CYC(0), .INIT_FILE("")) u1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (b1.slave)
    );

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    bit en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    int wcyc [2] = '{2, 0};
    int depth [2] = '{1024, 16};

    logic [31:0] mm [2][1024];

    bit          p_act [2] = '{1'b0, 1'b0};
    int          p_iss [2];
    logic        p_we  [2];
    logic [31:0] p_a   [2];
    logic [31:0] p_wd  [2];
    logic [2:0]  p_t   [2];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Outcome of one access from the memory image alone.
    function automatic void predict(
        input  int d,
        input  logic we,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        input  logic [2:0] t,
        output logic [31:0] rd,
        output logic e,
        output logic [31:0] nw,
        output int ix
    );
        int     sz;
        int     off;
        longint v;
        longint old;
        off = int'(a % 4);
        ix  = int'((a / 4) % depth[d]);
        case (t)
            3'd0:       sz = 4;
            3'd1, 3'd2: sz = 2;
            3'd3, 3'd4: sz = 1;
            default:    sz = 0;
        endcase
        old = longint'(mm[d][ix]);
        nw  = mm[d][ix];
        rd  = 32'h0;
        if (sz == 0) e = 1'b1;
        else         e = (off % sz) != 0;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < sz; i++)
                    nw[8*(off+i) +: 8] = wd[8*i +: 8];
            end else begin
                v = (old >> (8*off)) & ((64'd1 << (8*sz)) - 1);
                if ((t == 3'd1 || t == 3'd3) &&
                    v >= longint'(64'd1 << (8*sz-1)))
                    v = v - longint'(64'd1 << (8*sz));
                rd = v[31:0];
            end
        end
    endfunction

    logic        dn, st, er, xe;
    logic [31:0] rdv, xr, nw;
    bit          ed, es;
    int          ix;

    always @(negedge clk) begin
        if (en) begin
            for (int d = 0; d < 2; d++) begin
                dn  = (d == 0) ? b0.done  : b1.done;
                st  = (d == 0) ? b0.stall : b1.stall;
                er  = (d == 0) ? b0.err   : b1.err;
                rdv = (d == 0) ? b0.rdata : b1.rdata;
                ed = p_act[d] &&
                     cyc == p_iss[d] + wcyc[d] + 1;
                es = p_act[d] && cyc >= p_iss[d] &&
                     cyc <= p_iss[d] + wcyc[d];
                chk($sformatf("done%0d c%0d", d, cyc), 32'(dn), 32'(ed));
                chk($sformatf("stall%0d c%0d", d, cyc), 32'(st), 32'(es));
                if (ed) begin
                    predict(d, p_we[d], p_a[d], p_wd[d], p_t[d],
                            xr, xe, nw, ix);
                    chk($sformatf("rdata%0d a%h", d, p_a[d]), rdv, xr);
                    chk($sformatf("err%0d a%h", d, p_a[d]),
                        32'(er), 32'(xe));
                    if (p_we[d] && !xe) mm[d][ix] = nw;
                    p_act[d] = 1'b0;
                end
            end
        end
    end

    task automatic drive(input int d, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] t);
        if (d == 0) begin
            b0.req = r; b0.we = w; b0.addr = a;
            b0.wdata = wd; b0.dmtype = t; b0.pc = 32'h1000 + a;
        end else begin
            b1.req = r; b1.we = w; b1.addr = a;
            b1.wdata = wd; b1.dmtype = t; b1.pc = 32'h2000 + a;
        end
    endtask

    task automatic issue(input int d, input logic w,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] t);
        drive(d, 1'b1, w, a, wd, t);
        p_we[d] = w; p_a[d] = a; p_wd[d] = wd; p_t[d] = t;
        p_iss[d] = cyc;
        p_act[d] = 1'b1;
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, 32'h0, 32'h0, DM_WORD);
    endtask

    // Literal expectation pins the model; the DUT is checked
    // against the model by the negedge process.
    task automatic acc(input int d, input logic w,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] t, input logic [31:0] xrd,
                       input logic xer, input string nm);
        logic [31:0] r, n;
        logic        e;
        int          k;
        predict(d, w, a, wd, t, r, e, n, k);
        chk({nm, " model rdata"}, r, xrd);
        chk({nm, " model err"}, 32'(e), 32'(xer));
        issue(d, w, a, wd, t);
        while (cyc < p_iss[d] + wcyc[d] + 2) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, DM_WORD);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, DM_WORD);
        repeat (3) @(posedge clk);
        #1;
        chk("rst done", 32'(b0.done), 32'd0);
        chk("rst rdata", b0.rdata, 32'h0);
        chk("rst err", 32'(b0.err), 32'd0);
        chk("rst stall", 32'(b0.stall), 32'd0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        en   = 1'b1;
        @(posedge clk); #1;

        acc(0, 1, 32'h10, 32'hDEADBEEF, DM_WORD, 32'h0, 0, "st w");
        acc(0, 0, 32'h10, 32'h0, DM_WORD, 32'hDEADBEEF, 0, "ld w");
        acc(0, 1, 32'h10, 32'h0, DM_WORD, 32'h0, 0, "clr");
        acc(0, 1, 32'h11, 32'h7F, DM_BYTE, 32'h0, 0, "st b");
        acc(0, 0, 32'h10, 32'h0, DM_WORD, 32'h00007F00, 0, "ld mrg");
        acc(0, 1, 32'h10, 32'h80FF0000, DM_WORD, 32'h0, 0, "st w2");
        acc(0, 0, 32'h13, 32'h0, DM_BYTE, 32'hFFFFFF80, 0, "ld bs");
        acc(0, 0, 32'h13, 32'h0, DM_BYTE_U, 32'h00000080, 0, "ld bu");
        acc(0, 1, 32'h10, 32'h80011234, DM_WORD, 32'h0, 0, "st w3");
        acc(0, 0, 32'h12, 32'h0, DM_HALF_U, 32'h00008001, 0, "ld hu");
        acc(0, 0, 32'h12, 32'h0, DM_HALF, 32'hFFFF8001, 0, "ld hs");
        acc(0, 0, 32'h10, 32'h0, DM_HALF, 32'h00001234, 0, "ld hs lo");
        acc(0, 0, 32'h1010, 32'h0, DM_WORD, 32'h80011234, 0, "ld wrap");

        acc(0, 1, 32'h00, 32'h11111111, DM_WORD, 32'h0, 0, "st w0");
        acc(0, 1, 32'h02, 32'hAAAAAAAA, DM_WORD, 32'h0, 1, "mis w");
        acc(0, 1, 32'h00, 32'hBBBBBBBB, 3'b110, 32'h0, 1, "bad t");
        acc(0, 1, 32'h01, 32'hCCCC, DM_HALF, 32'h0, 1, "mis h");
        acc(0, 0, 32'h03, 32'h0, DM_HALF_U, 32'h0, 1, "mis hl");
        acc(0, 0, 32'h00, 32'h0, DM_WORD, 32'h11111111, 0, "ld w0");
        acc(0, 1, 32'h04, 32'h11111111, DM_WORD, 32'h0, 0, "st w4");
        acc(0, 1, 32'h06, 32'hFFFFABCD, DM_HALF, 32'h0, 0, "st h");
        acc(0, 0, 32'h04, 32'h0, DM_WORD, 32'hABCD1111, 0, "ld h mrg");

        acc(0, 1, 32'h20, 32'hCAFEF00D, DM_WORD, 32'h0, 0, "st 20");
        issue(0, 1'b1, 32'h20, 32'h12345678, DM_WORD);
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        p_act[0] = 1'b0;
        chk("rst mid done", 32'(b0.done), 32'd0);
        chk("rst mid stall", 32'(b0.stall), 32'd0);
        chk("rst mid rdata", b0.rdata, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        acc(0, 0, 32'h20, 32'h0, DM_WORD, 32'hCAFEF00D, 0, "ld 20");

        acc(1, 1, 32'h40, 32'h5A5AA5A5, DM_WORD, 32'h0, 0, "w st40");
        acc(1, 0, 32'h00, 32'h0, DM_WORD, 32'h5A5AA5A5, 0, "w ld00");
        acc(1, 1, 32'h43, 32'h99, DM_BYTE, 32'h0, 0, "w st b");
        acc(1, 0, 32'h03, 32'h0, DM_BYTE_U, 32'h00000099, 0, "w ld bu");
        acc(1, 0, 32'h83, 32'h0, DM_BYTE, 32'hFFFFFF99, 0, "w ld bs");
        acc(1, 0, 32'h00, 32'h0, DM_WORD, 32'h995AA5A5, 0, "w ld w");

        repeat (3) @(posedge clk);
        #1;
        en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
